// File: rtl/blackjack_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blackjack_round_ctrl : deals one blackjack round, runs the player/dealer    |
// | turns and resolves the result. BLACKJACK_SOFT_ACE_EN enables soft aces.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module blackjack_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  input  logic       player_hit,
  input  logic       player_stand,
  output logic       card_req,
  output logic       card_to_dealer,
  output logic [5:0] player_hand,
  output logic [5:0] dealer_hand,
  output logic [1:0] game_result,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] c_bust_limit   = 6'(BUST_LIMIT);
  localparam logic [5:0] c_dealer_stand = 6'(DEALER_STAND);

  localparam logic [3:0] c_idle        = 4'd0;
  localparam logic [3:0] c_deal_p1     = 4'd1;
  localparam logic [3:0] c_deal_d1     = 4'd2;
  localparam logic [3:0] c_deal_p2     = 4'd3;
  localparam logic [3:0] c_deal_d2     = 4'd4;
  localparam logic [3:0] c_player_turn = 4'd5;
  localparam logic [3:0] c_player_draw = 4'd6;
  localparam logic [3:0] c_dealer_turn = 4'd7;
  localparam logic [3:0] c_dealer_draw = 4'd8;
  localparam logic [3:0] c_resolve     = 4'd9;
  localparam logic [3:0] c_done        = 4'd10;

  logic [3:0] r_state;
  logic [5:0] r_player_hand;
  logic [5:0] r_dealer_hand;
  logic [1:0] r_result;
  logic       r_done;

  logic       w_accept;
  logic [3:0] w_card;
  logic [5:0] w_tgt_hand;
  logic [5:0] w_new_hand;
  logic       w_player_bust;
  logic       w_dealer_bust;
  logic [1:0] w_result;

  always_comb begin
    card_req       = 1'b0;
    card_to_dealer = 1'b0;
    case (r_state)
      c_deal_p1, c_deal_p2, c_player_draw: card_req = 1'b1;
      c_deal_d1, c_deal_d2, c_dealer_draw: begin
        card_req       = 1'b1;
        card_to_dealer = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != c_idle) && (r_state != c_done);
  assign done        = r_done;
  assign player_hand = r_player_hand;
  assign dealer_hand = r_dealer_hand;
  assign game_result = r_result;

  // Rank 0 is never a card; ranks above 10 count as a face card.
  assign w_accept   = card_req && card_valid && (card_value != 4'd0);
  assign w_card     = (card_value > 4'd10) ? 4'd10 : card_value;
  assign w_tgt_hand = card_to_dealer ? r_dealer_hand : r_player_hand;

  assign w_player_bust = r_player_hand > c_bust_limit;
  assign w_dealer_bust = r_dealer_hand > c_bust_limit;

  always_comb begin
    if (w_player_bust)                     w_result = 2'b10;
    else if (w_dealer_bust)                w_result = 2'b01;
    else if (r_player_hand > r_dealer_hand) w_result = 2'b01;
    else if (r_player_hand < r_dealer_hand) w_result = 2'b10;
    else                                   w_result = 2'b11;
  end

`ifdef BLACKJACK_SOFT_ACE_EN
  logic       r_player_soft;
  logic       r_dealer_soft;
  logic       w_tgt_soft;
  logic       w_ace_high;
  logic       w_soft_sum;
  logic       w_new_soft;
  logic [5:0] w_raw_sum;

  // An ace counts 11 when it fits; a soft hand that overshoots drops back by 10.
  always_comb begin
    w_tgt_soft = card_to_dealer ? r_dealer_soft : r_player_soft;
    w_ace_high = (card_value == 4'd1) && ((w_tgt_hand + 6'd11) <= c_bust_limit);
    w_raw_sum  = w_tgt_hand + (w_ace_high ? 6'd11 : {2'b00, w_card});
    w_soft_sum = w_tgt_soft || w_ace_high;
    if (w_soft_sum && (w_raw_sum > c_bust_limit)) begin
      w_new_hand = w_raw_sum - 6'd10;
      w_new_soft = 1'b0;
    end else begin
      w_new_hand = w_raw_sum;
      w_new_soft = w_soft_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_player_soft <= 1'b0;
      r_dealer_soft <= 1'b0;
    end else if (((r_state == c_idle) || (r_state == c_done)) && start) begin
      r_player_soft <= 1'b0;
      r_dealer_soft <= 1'b0;
    end else if (w_accept) begin
      if (card_to_dealer) r_dealer_soft <= w_new_soft;
      else                r_player_soft <= w_new_soft;
    end
  end
`else
  assign w_new_hand = w_tgt_hand + {2'b00, w_card};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_idle;
      r_player_hand <= 6'd0;
      r_dealer_hand <= 6'd0;
      r_result      <= 2'b00;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (card_to_dealer) r_dealer_hand <= w_new_hand;
        else                r_player_hand <= w_new_hand;
      end
      case (r_state)
        c_idle, c_done: begin
          if (start) begin
            r_player_hand <= 6'd0;
            r_dealer_hand <= 6'd0;
            r_result      <= 2'b00;
            r_state       <= c_deal_p1;
          end
        end
        c_deal_p1: if (w_accept) r_state <= c_deal_d1;
        c_deal_d1: if (w_accept) r_state <= c_deal_p2;
        c_deal_p2: if (w_accept) r_state <= c_deal_d2;
        c_deal_d2: if (w_accept) r_state <= c_player_turn;
        c_player_turn: begin
          if (w_player_bust)     r_state <= c_resolve;
          else if (player_stand) r_state <= c_dealer_turn;
          else if (player_hit)   r_state <= c_player_draw;
        end
        c_player_draw: if (w_accept) r_state <= c_player_turn;
        c_dealer_turn: begin
          if (r_dealer_hand < c_dealer_stand) r_state <= c_dealer_draw;
          else                                r_state <= c_resolve;
        end
        c_dealer_draw: if (w_accept) r_state <= c_dealer_turn;
        c_resolve: begin
          r_result <= w_result;
          r_done   <= 1'b1;
          r_state  <= c_done;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blackjack_round_ctrl.sv
`default_nettype none
// Self-checking bench for blackjack_round_ctrl: scripted rounds with a result scoreboard.
module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic       player_hit = 1'b0;
  logic       player_stand = 1'b0;
  logic       card_req;
  logic       card_to_dealer;
  logic [5:0] player_hand;
  logic [5:0] dealer_hand;
  logic [1:0] game_result;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] sb_exp;

  blackjack_round_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .card_valid(card_valid),
    .card_value(card_value), .player_hit(player_hit), .player_stand(player_stand),
    .card_req(card_req), .card_to_dealer(card_to_dealer), .player_hand(player_hand),
    .dealer_hand(dealer_hand), .game_result(game_result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the next expected {result, player, dealer}.
  always @(posedge clk) begin
    #1;
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 result=%b but no round was expected", game_result);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({game_result, player_hand, dealer_hand} !== sb_exp) begin
          errors++;
          $display("FAIL round_result: got result=%b player=%0d dealer=%0d, expected result=%b player=%0d dealer=%0d",
                   game_result, player_hand, dealer_hand, sb_exp[13:12], sb_exp[11:6], sb_exp[5:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic deliver(input logic [3:0] v, output bit ok, output bit to_d);
    ok = 1'b0;
    to_d = 1'b0;
    for (int n = 0; n < 20 && !card_req; n++) step();
    if (card_req) begin
      to_d = card_to_dealer;
      card_valid = 1'b1;
      card_value = v;
      step();
      card_valid = 1'b0;
      card_value = 4'd0;
      ok = 1'b1;
    end
  endtask

  task automatic deal4(input logic [3:0] p1, input logic [3:0] d1, input logic [3:0] p2,
                       input logic [3:0] d2, output bit ok, output logic [3:0] dests);
    bit o, t;
    ok = 1'b1;
    deliver(p1, o, t); ok &= o; dests[3] = t;
    deliver(d1, o, t); ok &= o; dests[2] = t;
    deliver(p2, o, t); ok &= o; dests[1] = t;
    deliver(d2, o, t); ok &= o; dests[0] = t;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({busy, card_req, card_to_dealer, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/req/to_dealer/done=%b, expected 0000", {busy, card_req, card_to_dealer, done});
    end
    checks++;
    if ({player_hand, dealer_hand, game_result} !== 14'd0) begin
      errors++;
      $display("FAIL reset_data: player=%0d dealer=%0d result=%b, expected 0 0 00", player_hand, dealer_hand, game_result);
    end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: busy=%b without start, expected 0", busy);
    end
  endtask

  task automatic test_player_bust();
    bit ok, seen;
    logic [3:0] dests;
    start_round();
    deal4(4'd10, 4'd5, 4'd6, 4'd7, ok, dests);
    checks++;
    if (!ok || dests !== 4'b0101) begin
      errors++;
      $display("FAIL bust_deal: ok=%b dests=%b, expected ok=1 dests=0101", ok, dests);
    end
    exp_q.push_back({2'b10, 6'd25, 6'd12});
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
    deliver(4'd9, ok, seen);
    checks++;
    if (!ok || seen !== 1'b0 || player_hand !== 6'd25) begin
      errors++;
      $display("FAIL bust_hit: ok=%b to_dealer=%b player=%0d, expected 1 0 25", ok, seen, player_hand);
    end
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bust_done: done=0 after 40 cycles, expected a pulse");
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bust_pulse: done=%b busy=%b one cycle later, expected 0 0", done, busy);
    end
  endtask

  task automatic test_dealer_draws();
    bit ok, t, seen;
    logic [3:0] dests;
    start_round();
    checks++;
    if ({player_hand, dealer_hand, game_result} !== 14'd0) begin
      errors++;
      $display("FAIL restart_clear: player=%0d dealer=%0d result=%b, expected 0 0 00", player_hand, dealer_hand, game_result);
    end
    deal4(4'd10, 4'd6, 4'd9, 4'd4, ok, dests);
    checks++;
    if (!ok || player_hand !== 6'd19 || dealer_hand !== 6'd10) begin
      errors++;
      $display("FAIL draw_deal: ok=%b player=%0d dealer=%0d, expected 1 19 10", ok, player_hand, dealer_hand);
    end
    exp_q.push_back({2'b01, 6'd19, 6'd18});
    player_stand = 1'b1;
    step();
    player_stand = 1'b0;
    deliver(4'd5, ok, t);
    checks++;
    if (!ok || t !== 1'b1 || dealer_hand !== 6'd15) begin
      errors++;
      $display("FAIL dealer_draw1: ok=%b to_dealer=%b dealer=%0d, expected 1 1 15", ok, t, dealer_hand);
    end
    deliver(4'd3, ok, t);
    checks++;
    if (!ok || t !== 1'b1 || dealer_hand !== 6'd18) begin
      errors++;
      $display("FAIL dealer_draw2: ok=%b to_dealer=%b dealer=%0d, expected 1 1 18", ok, t, dealer_hand);
    end
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL draw_done: done=0 after 40 cycles, expected a pulse");
    end
  endtask

  task automatic test_push_handshake();
    bit ok, seen;
    logic [3:0] dests;
    start_round();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (card_req !== 1'b1 || card_to_dealer !== 1'b0 || player_hand !== 6'd0) begin
      errors++;
      $display("FAIL idle_source: req=%b to_dealer=%b player=%0d, expected 1 0 0", card_req, card_to_dealer, player_hand);
    end
    card_valid = 1'b1;
    card_value = 4'd0;
    step();
    card_valid = 1'b0;
    checks++;
    if (card_req !== 1'b1 || card_to_dealer !== 1'b0 || player_hand !== 6'd0) begin
      errors++;
      $display("FAIL zero_card: req=%b to_dealer=%b player=%0d, expected 1 0 0", card_req, card_to_dealer, player_hand);
    end
    deal4(4'd12, 4'd13, 4'd8, 4'd8, ok, dests);
    checks++;
    if (!ok || player_hand !== 6'd18 || dealer_hand !== 6'd18) begin
      errors++;
      $display("FAIL face_cards: ok=%b player=%0d dealer=%0d, expected 1 18 18", ok, player_hand, dealer_hand);
    end
    exp_q.push_back({2'b11, 6'd18, 6'd18});
    player_stand = 1'b1;
    step();
    player_stand = 1'b0;
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL push_done: done=0 after 40 cycles, expected a pulse");
    end
  endtask

  task automatic test_hit_stand_start_busy();
    bit ok, t, seen;
    start_round();
    deliver(4'd5, ok, t);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || card_to_dealer !== 1'b1 || player_hand !== 6'd5) begin
      errors++;
      $display("FAIL start_busy: busy=%b to_dealer=%b player=%0d, expected 1 1 5", busy, card_to_dealer, player_hand);
    end
    deliver(4'd9, ok, t);
    deliver(4'd4, ok, t);
    deliver(4'd8, ok, t);
    exp_q.push_back({2'b10, 6'd9, 6'd17});
    player_hit = 1'b1;
    player_stand = 1'b1;
    step();
    player_hit = 1'b0;
    player_stand = 1'b0;
    checks++;
    if (card_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hit_and_stand: req=%b busy=%b, expected 0 1 (dealer turn)", card_req, busy);
    end
    wait_done(seen);
    checks++;
    if (!seen || player_hand !== 6'd9 || dealer_hand !== 6'd17) begin
      errors++;
      $display("FAIL stand_17: seen=%b player=%0d dealer=%0d, expected 1 9 17", seen, player_hand, dealer_hand);
    end
  endtask

  task automatic test_dealer_bust();
    bit ok, t, seen;
    logic [3:0] dests;
    start_round();
    deal4(4'd10, 4'd6, 4'd7, 4'd10, ok, dests);
    exp_q.push_back({2'b01, 6'd17, 6'd26});
    player_stand = 1'b1;
    step();
    player_stand = 1'b0;
    deliver(4'd10, ok, t);
    wait_done(seen);
    checks++;
    if (!ok || !seen || dealer_hand !== 6'd26) begin
      errors++;
      $display("FAIL dealer_bust: ok=%b seen=%b dealer=%0d, expected 1 1 26", ok, seen, dealer_hand);
    end
  endtask

  task automatic test_soft_ace();
    bit ok, t, seen;
    logic [3:0] dests;
    logic [5:0] exp_two;
`ifdef BLACKJACK_SOFT_ACE_EN
    exp_two = 6'd17;
`else
    exp_two = 6'd7;
`endif
    start_round();
    deal4(4'd1, 4'd5, 4'd6, 4'd5, ok, dests);
    checks++;
    if (!ok || player_hand !== exp_two) begin
      errors++;
      $display("FAIL ace_deal: ok=%b player=%0d, expected 1 %0d", ok, player_hand, exp_two);
    end
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
    deliver(4'd10, ok, t);
    checks++;
    if (!ok || player_hand !== 6'd17) begin
      errors++;
      $display("FAIL ace_hit: ok=%b player=%0d, expected 1 17", ok, player_hand);
    end
    exp_q.push_back({2'b11, 6'd17, 6'd17});
    player_stand = 1'b1;
    step();
    player_stand = 1'b0;
    deliver(4'd7, ok, t);
    wait_done(seen);
    checks++;
    if (!ok || !seen) begin
      errors++;
      $display("FAIL ace_round: ok=%b seen=%b, expected 1 1 (player not bust)", ok, seen);
    end
  endtask

  task automatic test_reset_mid_deal();
    bit ok, t;
    start_round();
    deliver(4'd10, ok, t);
    deliver(4'd5, ok, t);
    reset = 1'b0;
    #2;
    checks++;
    if ({player_hand, dealer_hand, game_result} !== 14'd0 || card_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: player=%0d dealer=%0d result=%b req=%b busy=%b, expected 0 0 00 0 0",
               player_hand, dealer_hand, game_result, card_req, busy);
    end
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (busy !== 1'b0 || card_req !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: busy=%b req=%b done=%b, expected 0 0 0", busy, card_req, done);
    end
    start_round();
    checks++;
    if (card_req !== 1'b1 || card_to_dealer !== 1'b0) begin
      errors++;
      $display("FAIL restart_after_reset: req=%b to_dealer=%b, expected 1 0", card_req, card_to_dealer);
    end
  endtask

  initial begin
    test_reset();
    test_player_bust();
    test_dealer_draws();
    test_push_handshake();
    test_hit_stand_start_busy();
    test_dealer_bust();
    test_soft_ace();
    test_reset_mid_deal();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected rounds never completed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
